scanout_engine: RTL

- Parametrised single-clock successor to the current frame-buffer display path.
- Generates VGA timing and frame-buffer read addresses, with pixel replication (SCALE) and double-buffered page select.
- Compensates for the RAM read latency and drives blanked, sync-aligned colour outputs.
- Sits between the dual-port frame buffer's read port and the VGA pins, replacing separate controller, translator and porch logic.

---
 rtl/scanout_engine.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/scanout_engine.sv
// scanout_engine: single-clock VGA scanout path. Generates the raster
// timing, walks the frame buffer with pixel/line replication, selects one
// of two pages per frame, and lines the returned pixels up with the
// delayed sync and blanking signals.
module scanout_engine #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit SYNC_POL    = 1'b0,
  parameter int SCALE       = 2,
  parameter int PIXEL_BITS  = 4,
  parameter int COLOR_BITS  = 4,
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_WIDTH  = 18
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  page_sel_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_rd_en_o,
  input  logic [PIXEL_BITS-1:0] mem_rd_data_i,
  output logic [COLOR_BITS-1:0] vga_r_o,
  output logic [COLOR_BITS-1:0] vga_g_o,
  output logic [COLOR_BITS-1:0] vga_b_o,
  output logic                  vga_hs_o,
  output logic                  vga_vs_o,
  output logic                  display_en_o,
  output logic                  active_page_o,
  output logic                  frame_start_o
);

  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FB_W      = H_ACTIVE / SCALE;
  localparam int FB_H      = V_ACTIVE / SCALE;
  localparam int PAGE_SIZE = FB_W * FB_H;
  localparam int HW        = $clog2(H_TOTAL + 1);
  localparam int VW        = $clog2(V_TOTAL + 1);
  localparam int RW        = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int CW        = (FB_W > 1) ? $clog2(FB_W) : 1;
  localparam int PIPE      = MEM_LATENCY + 1;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } timing_t;

  state_e                state_q, state_d;
  logic [HW-1:0]         h_cnt_q, h_cnt_d;
  logic [VW-1:0]         v_cnt_q, v_cnt_d;
  logic                  active_page_q, active_page_d;
  logic                  frame_start_q, frame_start_d;

  logic [RW-1:0]         hrep_q, hrep_d;
  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         vrep_q, vrep_d;
  logic [ADDR_WIDTH-1:0] line_base_q, line_base_d;

  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  mem_rd_en_q;
  timing_t [PIPE-1:0]    pipe_q;

  logic                  running;
  logic                  h_active, v_active, pos_active;
  logic                  last_pix, last_line;
  logic                  hs_now, vs_now;
  logic [ADDR_WIDTH-1:0] page_base, addr_now;
  timing_t               timing_now;
  logic [COLOR_BITS-1:0] pixel_color;

  // Decode the current raster position into active, sync and wrap flags.
  assign running   = (state_q == ST_RUN);
  assign h_active  = (h_cnt_q < HW'(H_ACTIVE));
  assign v_active  = (v_cnt_q < VW'(V_ACTIVE));
  assign last_pix  = (h_cnt_q == HW'(H_TOTAL - 1));
  assign last_line = (v_cnt_q == VW'(V_TOTAL - 1));
  assign pos_active = running && h_active && v_active;
  assign hs_now = running && (h_cnt_q >= HW'(H_ACTIVE + H_FP))
                          && (h_cnt_q <  HW'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_now = running && (v_cnt_q >= VW'(V_ACTIVE + V_FP))
                          && (v_cnt_q <  VW'(V_ACTIVE + V_FP + V_SYNC));
  assign timing_now = '{de: pos_active, hs: hs_now, vs: vs_now};

  // Page offset is either zero or one page, so no multiplier is needed.
  assign page_base = active_page_q ? ADDR_WIDTH'(PAGE_SIZE) : '0;
  assign addr_now  = page_base + line_base_q + ADDR_WIDTH'(col_q);

  // Run state, raster counters, page latch and frame pulse next-state logic.
  always_comb begin
    state_d       = state_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    active_page_d = active_page_q;
    frame_start_d = 1'b0;
    if (!enable_i) begin
      state_d = ST_IDLE;
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d       = ST_RUN;
          h_cnt_d       = '0;
          v_cnt_d       = '0;
          active_page_d = page_sel_i;
          frame_start_d = 1'b1;
        end
        ST_RUN: begin
          if (last_pix) begin
            h_cnt_d = '0;
            if (last_line) begin
              v_cnt_d       = '0;
              active_page_d = page_sel_i;
              frame_start_d = 1'b1;
            end else begin
              v_cnt_d = v_cnt_q + VW'(1);
            end
          end else begin
            h_cnt_d = h_cnt_q + HW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Register the run state, raster position, page and frame pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      active_page_q <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      active_page_q <= active_page_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Walk the frame buffer incrementally: column every SCALE pixels, line
  // base every SCALE active lines, both cleared at their wraps.
  always_comb begin
    hrep_d      = hrep_q;
    col_d       = col_q;
    vrep_d      = vrep_q;
    line_base_d = line_base_q;
    if (!enable_i || !running) begin
      hrep_d      = '0;
      col_d       = '0;
      vrep_d      = '0;
      line_base_d = '0;
    end else begin
      if (pos_active) begin
        if (h_cnt_q == HW'(H_ACTIVE - 1)) begin
          hrep_d = '0;
          col_d  = '0;
        end else if (hrep_q == RW'(SCALE - 1)) begin
          hrep_d = '0;
          col_d  = col_q + CW'(1);
        end else begin
          hrep_d = hrep_q + RW'(1);
        end
      end
      if (last_pix) begin
        if (last_line) begin
          vrep_d      = '0;
          line_base_d = '0;
        end else if (v_active) begin
          if (vrep_q == RW'(SCALE - 1)) begin
            vrep_d      = '0;
            line_base_d = line_base_q + ADDR_WIDTH'(FB_W);
          end else begin
            vrep_d = vrep_q + RW'(1);
          end
        end
      end
    end
  end

  // Register the address-walk counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hrep_q      <= '0;
      col_q       <= '0;
      vrep_q      <= '0;
      line_base_q <= '0;
    end else begin
      hrep_q      <= hrep_d;
      col_q       <= col_d;
      vrep_q      <= vrep_d;
      line_base_q <= line_base_d;
    end
  end

  // Issue a registered read for every visible pixel; the address holds in blanking.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_addr_q  <= '0;
      mem_rd_en_q <= 1'b0;
    end else begin
      mem_rd_en_q <= enable_i && pos_active;
      if (enable_i && pos_active) begin
        mem_addr_q <= addr_now;
      end
    end
  end

  // Delay blanking and sync so they arrive together with the read data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_q <= '0;
    end else if (!enable_i) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= timing_now;
      for (int i = 1; i < PIPE; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  // Left-align and bit-replicate the pixel, blanking it outside the visible area.
  always_comb begin
    pixel_color = '0;
    if (pipe_q[PIPE-1].de) begin
      for (int i = 0; i < COLOR_BITS; i++) begin
        pixel_color[COLOR_BITS-1-i] = mem_rd_data_i[PIXEL_BITS-1-(i % PIXEL_BITS)];
      end
    end
  end

  assign mem_addr_o    = mem_addr_q;
  assign mem_rd_en_o   = mem_rd_en_q;
  assign vga_r_o       = pixel_color;
  assign vga_g_o       = pixel_color;
  assign vga_b_o       = pixel_color;
  assign vga_hs_o      = pipe_q[PIPE-1].hs ? SYNC_POL : ~SYNC_POL;
  assign vga_vs_o      = pipe_q[PIPE-1].vs ? SYNC_POL : ~SYNC_POL;
  assign display_en_o  = pipe_q[PIPE-1].de;
  assign active_page_o = active_page_q;
  assign frame_start_o = frame_start_q;

endmodule
